bcd2seg_scan_ndigit: RTL and testbench

- Parametrised N-digit multiplexed BCD-to-7-segment display driver; successor to the 2-digit converter.
- Steps through the digits on an external scan tick and drives one-hot digit enables, segment data and a decimal point.
- Snapshots the BCD bus once per frame so a frame never mixes old and new digit values.
- Sits between the stop-watch/counter BCD outputs and the board's display pins.

---
 rtl/bcd2seg_scan_ndigit_if.sv | 24 ++
 rtl/bcd2seg_scan_ndigit.sv | 139 +++++++++++++
 tb/tb_bcd2seg_scan_ndigit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd2seg_scan_ndigit_if.sv
// rtl/bcd2seg_scan_ndigit_if.sv - scan-driver bus: BCD/dp/blank inputs, tick/enable, digit and segment pins
interface bcd2seg_scan_ndigit_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    scan_tick;
  logic                    seg_en;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              segd;
  logic                    dp;
  logic                    frame_start;

  modport master (
    output scan_tick, seg_en, bcd_in, dp_in, blank_in,
    input  an, segd, dp, frame_start
  );

  modport slave (
    input  scan_tick, seg_en, bcd_in, dp_in, blank_in,
    output an, segd, dp, frame_start
  );
endinterface

// File: rtl/bcd2seg_scan_ndigit.sv
// rtl/bcd2seg_scan_ndigit.sv - N-digit multiplexed BCD-to-7-segment scan driver (leading-zero blanking under BCD2SEG_LZB_EN)
module bcd2seg_scan_ndigit #(
  parameter int NUM_DIGITS  = 4,
  parameter bit SEG_ACT_LOW = 1'b0,
  parameter bit AN_ACT_LOW  = 1'b0
) (
  input logic                    clk,
  input logic                    rst,
  bcd2seg_scan_ndigit_if.slave   bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [IDX_W-1:0]        idx_q;
  logic [IDX_W-1:0]        idx_next;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] snap_bcd_q;
  logic [NUM_DIGITS-1:0]   snap_dp_q;
  logic [NUM_DIGITS-1:0]   snap_blank_q;

  logic [4*NUM_DIGITS-1:0] src_bcd;
  logic [NUM_DIGITS-1:0]   src_dp;
  logic [NUM_DIGITS-1:0]   src_blank;
  logic [NUM_DIGITS-1:0]   lead_zero;

  logic [3:0]              cur_digit;
  logic                    cur_blank;
  logic [6:0]              cur_seg;
  logic                    cur_dp;
  logic [NUM_DIGITS-1:0]   cur_onehot;

  // Active-high internal copies; pin polarity is a fixed inversion on top.
  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic                    fs_q;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h27;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  // Next digit index; a wrap to digit 0 marks the start of a new frame.
  always_comb begin
    idx_next = idx_q;
    if (bus.scan_tick) begin
      idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    wrap = bus.scan_tick && (idx_next == '0);
  end

  // Digit 0 of a new frame decodes the live bus; every other digit uses the frame snapshot.
  always_comb begin
    src_bcd   = wrap ? bus.bcd_in   : snap_bcd_q;
    src_dp    = wrap ? bus.dp_in    : snap_dp_q;
    src_blank = wrap ? bus.blank_in : snap_blank_q;
  end

`ifdef BCD2SEG_LZB_EN
  logic zero_run;

  // A digit is a leading zero when it and every more significant digit are 0; digit 0 always shows.
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run     = zero_run && (src_bcd[4*k +: 4] == 4'd0);
      lead_zero[k] = zero_run;
    end
  end
`else
  assign lead_zero = '0;
`endif

  // Decode the digit about to be driven, applying forced and leading-zero blanking.
  always_comb begin
    cur_digit  = src_bcd[{idx_next, 2'b00} +: 4];
    cur_blank  = src_blank[idx_next] | lead_zero[idx_next];
    cur_seg    = cur_blank ? 7'h00 : decode(cur_digit);
    cur_dp     = !cur_blank && src_dp[idx_next];
    cur_onehot = '0;
    cur_onehot[idx_next] = 1'b1;
  end

  // Scan index, frame snapshot and frame-start pulse keep running even while the display is off.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= IDX_LAST;
      snap_bcd_q   <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= '0;
      fs_q         <= 1'b0;
    end else begin
      idx_q <= idx_next;
      fs_q  <= wrap;
      if (wrap) begin
        snap_bcd_q   <= bus.bcd_in;
        snap_dp_q    <= bus.dp_in;
        snap_blank_q <= bus.blank_in;
      end
    end
  end

  // Pin registers: segments update on each tick, digit enables drop immediately when disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= '0;
      seg_q <= '0;
      dp_q  <= 1'b0;
    end else begin
      if (bus.scan_tick) begin
        seg_q <= cur_seg;
        dp_q  <= cur_dp;
      end
      if (!bus.seg_en) begin
        an_q <= '0;
      end else if (bus.scan_tick) begin
        an_q <= cur_onehot;
      end
    end
  end

  assign bus.an          = an_q ^ {NUM_DIGITS{AN_ACT_LOW}};
  assign bus.segd        = seg_q ^ {7{SEG_ACT_LOW}};
  assign bus.dp          = dp_q ^ SEG_ACT_LOW;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_bcd2seg_scan_ndigit.sv
// tb/tb_bcd2seg_scan_ndigit.sv - self-checking bench for bcd2seg_scan_ndigit, both pin polarities
module tb_bcd2seg_scan_ndigit;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd2seg_scan_ndigit_if #(.NUM_DIGITS(N)) if1 ();
  bcd2seg_scan_ndigit_if #(.NUM_DIGITS(N)) if2 ();

  bcd2seg_scan_ndigit #(.NUM_DIGITS(N), .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  bcd2seg_scan_ndigit #(.NUM_DIGITS(N), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)) dut_low (
    .clk (clk),
    .rst (rst),
    .bus (if2.slave)
  );

  assign if2.scan_tick = if1.scan_tick;
  assign if2.seg_en    = if1.seg_en;
  assign if2.bcd_in    = if1.bcd_in;
  assign if2.dp_in     = if1.dp_in;
  assign if2.blank_in  = if1.blank_in;

  int checks   = 0;
  int failures = 0;

  int seg_tbl [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h27,
                       'h7F, 'h6F, 'h40, 'h40, 'h40, 'h40, 'h40, 'h40};

  int pos;
  int snap_d   [N];
  bit snap_dp  [N];
  bit snap_bl  [N];
  logic [N-1:0] e_an;
  logic [6:0]   e_seg;
  logic         e_dp;
  logic         e_fs;
  logic [N-1:0] e_an_n;
  logic [6:0]   e_seg_n;
  logic         e_dp_n;
  int exp_1234 [4] = '{'h66, 'h4F, 'h5B, 'h06};

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  function automatic bit lzb_blank(int k);
`ifdef BCD2SEG_LZB_EN
    if (k == 0) return 1'b0;
    for (int j = k; j < N; j++) if (snap_d[j] != 0) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model(input bit tick, input bit en, input bit r);
    bit bl;
    if (r) begin
      pos = N - 1;
      e_an = '0; e_seg = '0; e_dp = 1'b0; e_fs = 1'b0;
      for (int k = 0; k < N; k++) begin
        snap_d[k] = 0; snap_dp[k] = 1'b0; snap_bl[k] = 1'b0;
      end
    end else begin
      e_fs = 1'b0;
      if (tick) begin
        pos = (pos + 1) % N;
        if (pos == 0) begin
          for (int k = 0; k < N; k++) begin
            snap_d[k]  = int'(if1.bcd_in[4*k +: 4]);
            snap_dp[k] = if1.dp_in[k];
            snap_bl[k] = if1.blank_in[k];
          end
          e_fs = 1'b1;
        end
        bl    = snap_bl[pos] || lzb_blank(pos);
        e_seg = bl ? 7'h00 : 7'(seg_tbl[snap_d[pos]]);
        e_dp  = bl ? 1'b0 : snap_dp[pos];
      end
      if (!en) e_an = '0;
      else if (tick) e_an = N'(1) << pos;
    end
    e_an_n  = ~e_an;
    e_seg_n = ~e_seg;
    e_dp_n  = ~e_dp;
  endtask

  task automatic step(input bit tick, input bit en, input bit r, input string tag);
    if1.scan_tick = tick;
    if1.seg_en    = en;
    rst           = r;
    @(posedge clk);
    model(tick, en, r);
    #1;
    chk(tag, "an",     if1.an,          e_an);
    chk(tag, "segd",   if1.segd,        e_seg);
    chk(tag, "dp",     if1.dp,          e_dp);
    chk(tag, "fs",     if1.frame_start, e_fs);
    chk(tag, "an_lo",  if2.an,          e_an_n);
    chk(tag, "seg_lo", if2.segd,        e_seg_n);
    chk(tag, "dp_lo",  if2.dp,          e_dp_n);
  endtask

  initial begin
    if1.scan_tick = 1'b0;
    if1.seg_en    = 1'b0;
    if1.bcd_in    = '0;
    if1.dp_in     = '0;
    if1.blank_in  = '0;

    step(0, 0, 1, "reset");
    step(0, 0, 1, "reset");
    chk("reset_lo", "an",   if2.an,   32'hF);
    chk("reset_lo", "segd", if2.segd, 32'h7F);
    chk("reset_lo", "dp",   if2.dp,   32'h1);

    if1.bcd_in = 16'h1234;
    step(0, 1, 0, "idle");
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, "f1234");
      chk("f1234_dir", "segd", if1.segd, exp_1234[i]);
      chk("f1234_dir", "an",   if1.an,   32'(1) << i);
      chk("f1234_dir", "fs",   if1.frame_start, (i == 0) ? 32'h1 : 32'h0);
    end

    step(1, 1, 0, "mid0");
    step(1, 1, 0, "mid1");
    if1.bcd_in = 16'h5678;
    step(1, 1, 0, "mid2");
    chk("mid2_dir", "segd", if1.segd, 32'h5B);
    step(1, 1, 0, "mid3");
    chk("mid3_dir", "segd", if1.segd, 32'h06);
    step(1, 1, 0, "wrap8");
    chk("wrap8_dir", "segd", if1.segd, 32'h7F);
    for (int i = 0; i < 3; i++) step(1, 1, 0, "f5678");

    if1.bcd_in = 16'h00A5;
    if1.dp_in  = 4'b0010;
    step(1, 1, 0, "a5_d0");
    chk("a5_dir", "segd", if1.segd, 32'h6D);
    step(1, 1, 0, "a5_d1");
    chk("a5_dir", "segd1", if1.segd, 32'h40);
    chk("a5_dir", "dp1",   if1.dp,   32'h1);
    step(1, 1, 0, "a5_d2");
    step(1, 1, 0, "a5_d3");

    if1.dp_in  = 4'b0100;
    if1.bcd_in = 16'h0005;
    for (int i = 0; i < 4; i++) step(1, 1, 0, "z0005");
    if1.bcd_in = 16'h0000;
    if1.dp_in  = '0;
    step(1, 1, 0, "z0000_d0");
    chk("z0000_dir", "segd", if1.segd, 32'h3F);
    for (int i = 0; i < 3; i++) step(1, 1, 0, "z0000");

    if1.bcd_in   = 16'h9071;
    if1.blank_in = 4'b0100;
    step(1, 1, 0, "en_a");
    step(1, 1, 0, "en_b");
    step(0, 0, 0, "en_off");
    chk("en_off_dir", "an", if1.an, 32'h0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, "en_low");
    step(0, 1, 0, "en_back");
    step(1, 1, 0, "en_resume");
    if1.blank_in = '0;

    for (int i = 0; i < N && pos != 2; i++) step(1, 1, 0, "to_idx2");
    step(0, 1, 1, "rst_mid");
    step(1, 1, 0, "rst_tick");
    chk("rst_tick_dir", "fs", if1.frame_start, 32'h1);
    chk("rst_tick_dir", "an", if1.an, 32'h1);

    for (int i = 0; i < 10; i++) begin
      if1.bcd_in = 16'($urandom);
      step(1, 1, 0, "held");
    end

    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++)
        if1.bcd_in[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if1.dp_in    = 4'($urandom);
      if1.blank_in = 4'($urandom) & 4'($urandom) & 4'($urandom);
      step(bit'($urandom_range(0, 1)), $urandom_range(0, 7) != 0, $urandom_range(0, 49) == 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
